// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg
// Shared definitions for the k-d tree node array and its root controller:
// bus widths, the command codes exchanged between tree levels, and the
// controller state enum.
package kd_tree_pkg;

  localparam int KD_DATA_W = 24;  // one packed 3x8-bit center
  localparam int KD_CMD_W  = 5;

  typedef logic [KD_CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_NOP                      = 5'h00;
  localparam cmd_t CMD_CENTER_FILL              = 5'h01;
  localparam cmd_t CMD_CONFIGURE_SORT_AXIS      = 5'h02;
  localparam cmd_t CMD_RECEIVE_CENTER           = 5'h03;
  localparam cmd_t CMD_CENTER_FILL_DONE         = 5'h05;
  localparam cmd_t CMD_CONFIGURE_SORT_AXIS_DONE = 5'h07;
  localparam cmd_t CMD_BUSY                     = 5'h08;
  localparam cmd_t CMD_START_SORTING            = 5'h09;
  localparam cmd_t CMD_READY_TO_SORT            = 5'h0a;
  localparam cmd_t CMD_DNE                      = 5'h10;
  localparam cmd_t CMD_RST_DONE                 = 5'h1e;
  localparam cmd_t CMD_RST                      = 5'h1f;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    TRST = 3'd2,
    FILL = 3'd3,
    CFG  = 3'd4,
    SORT = 3'd5
  } state_t;

endpackage

// File: rtl/kd_tree_root_ctrl_if.sv
// kd_tree_root_ctrl_if
// Bundles the host center stream and the root node's top-side ports.
//   center_valid/center_ready/center_data : host -> controller stream
//   command_to_root/data_to_root          : controller -> root node
//   command_from_root/data_from_root      : root node -> controller
// modport master: the controller side; modport slave: host + root side.
interface kd_tree_root_ctrl_if
  import kd_tree_pkg::*;
#(
  parameter int DATA_W = KD_DATA_W,
  parameter int CMD_W  = KD_CMD_W
);
  logic              center_valid;
  logic              center_ready;
  logic [DATA_W-1:0] center_data;
  logic [CMD_W-1:0]  command_to_root;
  logic [DATA_W-1:0] data_to_root;
  logic [CMD_W-1:0]  command_from_root;
  logic [DATA_W-1:0] data_from_root;

  modport master (
    input  center_valid, center_data, command_from_root, data_from_root,
    output center_ready, command_to_root, data_to_root
  );

  modport slave (
    output center_valid, center_data, command_from_root, data_from_root,
    input  center_ready, command_to_root, data_to_root
  );
endinterface

// File: rtl/kd_center_buffer.sv
// kd_center_buffer
// DEPTH x DATA_W center storage: one synchronous write port, one
// combinational read port. Storage is not reset; contents are only read
// after being written by the current load.
//   clk            : clock
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
module kd_center_buffer #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/kd_tree_root_ctrl.sv
// kd_tree_root_ctrl
// Upstream sequencer for the k-d tree node array. Buffers host centers,
// then drives the root through reset, center fill, sort-axis configuration
// and sorting, and reports the root's final center.
//   clk, rst_n          : clock, async active-low reset
//   start               : one-cycle request, accepted only in IDLE
//   n_centers, axis     : job parameters, sampled on accepted start
//   bus (master)        : host center stream + root command/data ports
//   busy                : high outside IDLE
//   done                : one-cycle completion pulse
//   root_center         : root data captured at completion
//   error               : sticky; cleared by reset or next accepted start
// Optional feature: define KD_ROOT_CTRL_TIMEOUT_EN to add a watchdog that
// aborts TRST/FILL/CFG/SORT after MAX_WAIT cycles in one state.
//
// state | meaning
// IDLE  | waiting for start, driving nop
// LOAD  | accepting n_centers host beats into the buffer
// TRST  | driving rst until the root answers rst_done
// FILL  | streaming buffered centers, last first, until center_fill_done
// CFG   | driving configure_sort_axis until its done reply
// SORT  | one start_sorting cycle, then waiting for STABLE_CYCLES quiet replies
module kd_tree_root_ctrl
  import kd_tree_pkg::*;
#(
  parameter int DATA_W        = KD_DATA_W,
  parameter int CMD_W         = KD_CMD_W,
  parameter int MAX_CENTERS   = 16,
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
  parameter int MAX_WAIT      = 1023,
`endif
  parameter int STABLE_CYCLES = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(MAX_CENTERS+1)-1:0]     n_centers,
  input  logic [1:0]                           axis,
  kd_tree_root_ctrl_if.master                  bus,
  output logic                                 busy,
  output logic                                 done,
  output logic [DATA_W-1:0]                    root_center,
  output logic                                 error
);
  localparam int CNT_W   = $clog2(MAX_CENTERS+1);
  localparam int IDX_W   = $clog2(MAX_CENTERS);
  localparam int QUIET_W = $clog2(STABLE_CYCLES+1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d, wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d, rd_addr;
  logic [1:0]          axis_q, axis_d;
  logic [QUIET_W-1:0]  quiet_q, quiet_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [DATA_W-1:0]   data_q, data_d, rc_q, rc_d, buf_rdata;
  logic                ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                buf_we;
  cmd_t                reply;

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT+1);
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                watched;
`endif

  assign reply = bus.command_from_root;

  kd_center_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_CENTERS), .AW(IDX_W)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx_q[IDX_W-1:0]),
    .wdata (bus.center_data),
    .raddr (rd_addr),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    axis_d   = axis_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    quiet_d  = quiet_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rc_d     = rc_q;
    buf_we   = 1'b0;
    rd_addr  = rd_idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_centers == '0 || n_centers > CNT_W'(MAX_CENTERS)) begin
            err_d = 1'b1;
          end else begin
            n_d      = n_centers;
            axis_d   = axis;
            err_d    = 1'b0;
            wr_idx_d = '0;
            ready_d  = 1'b1;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.center_valid && ready_q) begin
          buf_we   = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_d == n_q) begin
            ready_d = 1'b0;
            cmd_d   = CMD_RST;
            data_d  = '0;
            state_d = TRST;
          end
        end
      end
      TRST: begin
        if (reply == CMD_RST_DONE) begin
          // Fill starts with the last-loaded center so the first one ends up deepest.
          rd_addr  = IDX_W'(n_q - 1'b1);
          rd_idx_d = rd_addr;
          data_d   = buf_rdata;
          cmd_d    = CMD_CENTER_FILL;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (reply == CMD_CENTER_FILL_DONE) begin
          cmd_d   = CMD_CONFIGURE_SORT_AXIS;
          data_d  = DATA_W'(axis_q);
          state_d = CFG;
        end else begin
          // The tree shifts one word per cycle: step every cycle, park at 0.
          rd_addr  = (rd_idx_q == '0) ? '0 : rd_idx_q - 1'b1;
          rd_idx_d = rd_addr;
          data_d   = buf_rdata;
        end
      end
      CFG: begin
        if (reply == CMD_CONFIGURE_SORT_AXIS_DONE) begin
          cmd_d   = CMD_START_SORTING;
          data_d  = DATA_W'(axis_q);
          quiet_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        cmd_d  = CMD_NOP;
        data_d = '0;
        if (reply == CMD_READY_TO_SORT) begin
          if (quiet_q == QUIET_W'(STABLE_CYCLES-1)) begin
            done_d  = 1'b1;
            rc_d    = bus.data_from_root;
            state_d = IDLE;
          end else begin
            quiet_d = quiet_q + 1'b1;
          end
        end else begin
          quiet_d = '0;
        end
      end
      default: begin
        cmd_d   = CMD_NOP;
        data_d  = '0;
        state_d = IDLE;
      end
    endcase

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
    watched = (state_q == TRST) || (state_q == FILL) || (state_q == CFG) || (state_q == SORT);
    if (watched && wait_q == WAIT_W'(MAX_WAIT-1)) begin
      err_d   = 1'b1;
      done_d  = 1'b0;
      rc_d    = rc_q;
      cmd_d   = CMD_NOP;
      data_d  = '0;
      state_d = IDLE;
    end
`endif

    // The root must exist; a dne reply anywhere in a job aborts it.
    if (state_q != IDLE && reply == CMD_DNE) begin
      err_d   = 1'b1;
      done_d  = 1'b0;
      rc_d    = rc_q;
      buf_we  = 1'b0;
      ready_d = 1'b0;
      cmd_d   = CMD_NOP;
      data_d  = '0;
      state_d = IDLE;
    end

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
    if (state_d != state_q || state_d == IDLE || state_d == LOAD) wait_d = '0;
    else wait_d = wait_q + 1'b1;
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      axis_q   <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      quiet_q  <= '0;
      cmd_q    <= CMD_NOP;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rc_q     <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      axis_q   <= axis_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      quiet_q  <= quiet_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rc_q     <= rc_d;
    end
  end

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`endif

  assign bus.command_to_root = cmd_q;
  assign bus.data_to_root    = data_q;
  assign bus.center_ready    = ready_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign root_center         = rc_q;
  assign error               = err_q;
endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// Bench for kd_tree_root_ctrl. The stimulus flow plays host and root node,
// and for every cycle it states what the outputs must be after the next
// clock edge; one compare process checks the DUT against that.
module tb_kd_tree_root_ctrl;
  import kd_tree_pkg::*;

  localparam int MAXC = 16;
  localparam int STAB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  n_centers = '0;
  logic [1:0]  axis = '0;
  logic        busy, done, error;
  logic [23:0] root_center;

  kd_tree_root_ctrl_if bus ();

  kd_tree_root_ctrl #(
    .MAX_CENTERS   (MAXC),
`ifdef KD_ROOT_CTRL_TIMEOUT_EN
    .MAX_WAIT      (15),
`endif
    .STABLE_CYCLES (STAB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .n_centers   (n_centers),
    .axis        (axis),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .root_center (root_center),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs after the next rising edge.
  logic [4:0]  e_cmd = CMD_NOP;
  logic [23:0] e_data = '0, e_rc = '0;
  logic        e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  bit          chk_en = 1'b0;

  int          ss_cnt = 0, done_cnt = 0;
  logic [23:0] fill_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("command_to_root", bus.command_to_root, e_cmd);
      chk("data_to_root", bus.data_to_root, e_data);
      chk("center_ready", bus.center_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("error", error, e_err);
      chk("root_center", root_center, e_rc);
      if (bus.command_to_root == CMD_START_SORTING) ss_cnt++;
      if (done) done_cnt++;
      if (bus.command_to_root == CMD_CENTER_FILL) fill_q.push_back(bus.data_to_root);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_idle_exp();
    e_cmd = CMD_NOP; e_data = '0; e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0;
  endtask

  function automatic logic [4:0] filler(input logic [4:0] exitc);
    logic [4:0] c;
    do begin
      case ($urandom_range(0, 7))
        0: c = CMD_NOP;
        1: c = CMD_BUSY;
        2: c = CMD_RECEIVE_CENTER;
        3: c = CMD_RST_DONE;
        4: c = CMD_CENTER_FILL_DONE;
        5: c = CMD_CONFIGURE_SORT_AXIS_DONE;
        6: c = CMD_READY_TO_SORT;
        default: c = CMD_START_SORTING;
      endcase
    end while (c == exitc);
    return c;
  endfunction

  task automatic do_abort();
    bus.command_from_root = CMD_DNE;
    e_err = 1'b1;
    set_idle_exp();
    tick();
    bus.command_from_root = CMD_NOP;
    bus.center_valid = 1'b0;
  endtask

  // abort_ph: 0 none, 1 TRST, 2 FILL, 3 CFG, 4 SORT
  task automatic run_op(input int n, input logic [1:0] ax, input bit directed, input int abort_ph);
    logic [23:0] cen [MAXC];
    logic [23:0] dir_cen [3];
    logic [4:0]  dir_sort [7];
    logic [4:0]  r;
    int i, tw, fw, cw, q;
    bit fin;
    dir_cen  = '{24'h010203, 24'h040506, 24'h070809};
    dir_sort = '{CMD_READY_TO_SORT, CMD_READY_TO_SORT, CMD_BUSY, CMD_READY_TO_SORT,
                 CMD_READY_TO_SORT, CMD_READY_TO_SORT, CMD_READY_TO_SORT};
    for (int k = 0; k < n; k++) cen[k] = directed ? dir_cen[k] : 24'($urandom);

    bus.command_from_root = CMD_NOP;
    start = 1'b1; n_centers = 5'(n); axis = ax;
    e_busy = 1'b1; e_ready = 1'b1; e_err = 1'b0; e_cmd = CMD_NOP; e_data = '0; e_done = 1'b0;
    tick();
    start = 1'b0; n_centers = 5'($urandom); axis = 2'($urandom);

    i = 0;
    while (i < n) begin
      if (directed || $urandom_range(0, 2) == 0) begin
        // gap; a start here must be ignored
        bus.center_valid = 1'b0; bus.center_data = 24'($urandom);
        start = 1'($urandom_range(0, 1)); n_centers = '0;
        tick();
        start = 1'b0;
      end
      bus.center_valid = 1'b1; bus.center_data = cen[i]; i++;
      if (i == n) begin e_ready = 1'b0; e_cmd = CMD_RST; end
      tick();
    end
    // valid with ready low must not overwrite anything
    bus.center_valid = 1'b1; bus.center_data = 24'hdeadbe;

    tw = directed ? 2 : $urandom_range(0, 8);
    for (int k = 0; k < tw; k++) begin
      bus.command_from_root = directed ? CMD_NOP : filler(CMD_RST_DONE);
      tick();
    end
    if (abort_ph == 1) begin do_abort(); return; end
    bus.command_from_root = CMD_RST_DONE;
    e_cmd = CMD_CENTER_FILL; e_data = cen[n-1];
    tick();
    bus.center_valid = 1'b0;

    fw = directed ? 4 : $urandom_range(0, 8);
    for (int k = 1; k <= fw; k++) begin
      bus.command_from_root = directed ? CMD_NOP : filler(CMD_CENTER_FILL_DONE);
      e_data = cen[(n-1-k) > 0 ? (n-1-k) : 0];
      tick();
    end
    if (abort_ph == 2) begin do_abort(); return; end
    bus.command_from_root = CMD_CENTER_FILL_DONE;
    e_cmd = CMD_CONFIGURE_SORT_AXIS; e_data = 24'(ax);
    tick();
    if (directed) chk("cfg_data_literal", bus.data_to_root, 24'h000001);

    cw = directed ? 1 : $urandom_range(0, 8);
    for (int k = 0; k < cw; k++) begin
      bus.command_from_root = directed ? CMD_NOP : filler(CMD_CONFIGURE_SORT_AXIS_DONE);
      tick();
    end
    if (abort_ph == 3) begin do_abort(); return; end
    bus.command_from_root = CMD_CONFIGURE_SORT_AXIS_DONE;
    e_cmd = CMD_START_SORTING; e_data = 24'(ax);
    tick();
    if (abort_ph == 4) begin do_abort(); return; end

    e_cmd = CMD_NOP; e_data = '0;
    q = 0; fin = 1'b0;
    for (int it = 0; it < 64 && !fin; it++) begin
      if (directed) r = dir_sort[it];
      else if (it >= 6) r = CMD_READY_TO_SORT;
      else if ($urandom_range(0, 2) != 0) r = CMD_READY_TO_SORT;
      else r = $urandom_range(0, 1) ? CMD_BUSY : CMD_RECEIVE_CENTER;
      bus.command_from_root = r;
      bus.data_from_root = directed ? 24'h040506 : 24'($urandom);
      q = (r == CMD_READY_TO_SORT) ? q + 1 : 0;
      if (q == STAB) begin
        e_done = 1'b1; e_rc = bus.data_from_root; e_busy = 1'b0; fin = 1'b1;
      end
      tick();
      e_done = 1'b0;
    end
    if (!fin) chk("sort_loop_bound", 0, 1);
    bus.command_from_root = CMD_NOP;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.center_valid = 1'b0; bus.center_data = '0;
    bus.command_from_root = CMD_NOP; bus.data_from_root = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", bus.command_to_root, 5'h00);
    chk("rst_data", bus.data_to_root, 24'h0);
    chk("rst_ready", bus.center_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_root_center", root_center, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // directed job from the test plan
    fill_q.delete(); ss_cnt = 0; done_cnt = 0;
    run_op(3, 2'd1, 1'b1, 0);
    tick();
    chk("root_center_literal", root_center, 24'h040506);
    chk("start_sorting_cycles", ss_cnt, 1);
    chk("done_pulses", done_cnt, 1);
    chk("fill_len", fill_q.size(), 5);
    if (fill_q.size() == 5) begin
      chk("fill0", fill_q[0], 24'h070809);
      chk("fill1", fill_q[1], 24'h040506);
      chk("fill2", fill_q[2], 24'h010203);
      chk("fill3", fill_q[3], 24'h010203);
      chk("fill4", fill_q[4], 24'h010203);
    end

    // rejected starts
    start = 1'b1; n_centers = 5'd0; e_err = 1'b1;
    tick();
    start = 1'b0;
    chk("n0_error_literal", error, 1'b1);
    chk("n0_busy_literal", busy, 1'b0);
    start = 1'b1; n_centers = 5'd17;
    tick();
    start = 1'b0;
    tick();

    // dne during TRST
    run_op(2, 2'd2, 1'b0, 1);
    chk("dne_error_literal", error, 1'b1);
    chk("dne_busy_literal", busy, 1'b0);
    tick();

    // boundary counts then random jobs
    run_op(1, 2'd3, 1'b0, 0);
    tick();
    run_op(16, 2'd0, 1'b0, 0);
    tick();
    for (int t = 0; t < 30; t++) begin
      int n, ab;
      case ($urandom_range(0, 3))
        0: n = 1;
        1: n = 16;
        default: n = $urandom_range(1, 16);
      endcase
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
      run_op(n, 2'($urandom), 1'b0, ab);
      repeat ($urandom_range(0, 2)) tick();
    end

    // asynchronous reset in the middle of a load
    start = 1'b1; n_centers = 5'd4; axis = 2'd3;
    e_busy = 1'b1; e_ready = 1'b1; e_err = 1'b0; e_cmd = CMD_NOP; e_data = '0;
    tick();
    start = 1'b0; bus.center_valid = 1'b1; bus.center_data = 24'h123456;
    tick();
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", bus.center_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_root_center", root_center, 24'h0);
    chk("arst_cmd", bus.command_to_root, 5'h00);
    @(negedge clk);
    bus.center_valid = 1'b0;
    rst_n = 1'b1;
    set_idle_exp(); e_err = 1'b0; e_rc = '0;
    chk_en = 1'b1;
    tick();
    run_op(5, 2'd2, 1'b0, 0);
    tick();

`ifdef KD_ROOT_CTRL_TIMEOUT_EN
    // root never answers rst_done
    start = 1'b1; n_centers = 5'd1; axis = 2'd0;
    e_busy = 1'b1; e_ready = 1'b1; e_err = 1'b0; e_cmd = CMD_NOP; e_data = '0;
    tick();
    start = 1'b0; bus.center_valid = 1'b1; bus.center_data = 24'h0a0b0c;
    e_ready = 1'b0; e_cmd = CMD_RST;
    tick();
    bus.center_valid = 1'b0; bus.command_from_root = CMD_NOP;
    for (int c = 1; c < 15; c++) tick();
    e_err = 1'b1; set_idle_exp();
    tick();
    chk("watchdog_error_literal", error, 1'b1);
    chk("watchdog_busy_literal", busy, 1'b0);
    tick();
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
